// File: rtl/time_date_converter.sv
// Converts a 100 Hz tick count since 1970-01-01 into time, date and weekday.
// Shared restoring divider, then iterative year and month walks.
module time_date_converter #(
  parameter int EPOCH_YEAR    = 1970,
  parameter int EPOCH_DOW     = 4,
  parameter int MAX_YEAR      = 9999,
  parameter int TICKS_PER_SEC = 100
) (
  input  logic        clockSignal,
  input  logic        reset,
  input  logic        convertStart,
  input  logic [63:0] tickCount,
  output logic        busy,
  output logic        done,
  output logic [6:0]  centisecondsDisplay,
  output logic [5:0]  secondsDisplay,
  output logic [5:0]  minutesDisplay,
  output logic [4:0]  hoursDisplay,
  output logic [2:0]  dayOfWeekDisplay,
  output logic [4:0]  dateDisplay,
  output logic [3:0]  monthDisplay,
  output logic [13:0] yearDisplay,
  output logic        overflow
);

  typedef enum logic [3:0] {
    IDLE, DIV100, DIV60S, DIV60M, DIV24, DIV7, YEAR, MONTH, FINISH
  } state_t;

  localparam logic [13:0] Y0    = 14'(EPOCH_YEAR);
  localparam logic [13:0] YMAX  = 14'(MAX_YEAR);
  localparam logic [1:0]  R4_0  = 2'(EPOCH_YEAR % 4);
  localparam logic [6:0]  R1H_0 = 7'(EPOCH_YEAR % 100);
  localparam logic [8:0]  R4H_0 = 9'(EPOCH_YEAR % 400);

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] quo;
  logic [63:0] rem;
  logic [63:0] days;
  logic [6:0]  cs_w;
  logic [5:0]  sec_w;
  logic [5:0]  min_w;
  logic [4:0]  hr_w;
  logic [2:0]  dow_w;
  logic [13:0] year_w;
  logic [3:0]  month_w;
  logic [1:0]  r4;
  logic [6:0]  r100;
  logic [8:0]  r400;

  logic [63:0] divisor;
  logic [63:0] r_sh;
  logic [63:0] r_nx;
  logic [63:0] q_nx;
  logic        ge;
  logic        leap;
  logic [63:0] ylen;
  logic [63:0] mlen;

  always_comb begin
    divisor = 64'd1;
    case (state)
      DIV100:         divisor = 64'(TICKS_PER_SEC);
      DIV60S, DIV60M: divisor = 64'd60;
      DIV24:          divisor = 64'd24;
      DIV7:           divisor = 64'd7;
      default:        divisor = 64'd1;
    endcase
    r_sh = {rem[62:0], quo[63]};
    ge   = (r_sh >= divisor);
    r_nx = ge ? (r_sh - divisor) : r_sh;
    q_nx = {quo[62:0], ge};
    leap = (r4 == 2'd0) && ((r100 != 7'd0) || (r400 == 9'd0));
    ylen = leap ? 64'd366 : 64'd365;
    mlen = 64'd31;
    case (month_w)
      4'd2:                      mlen = leap ? 64'd29 : 64'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   mlen = 64'd30;
      default:                   mlen = 64'd31;
    endcase
  end

  always_ff @(posedge clockSignal) begin
    if (reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      quo                 <= '0;
      rem                 <= '0;
      days                <= '0;
      cs_w                <= '0;
      sec_w               <= '0;
      min_w               <= '0;
      hr_w                <= '0;
      dow_w               <= '0;
      year_w              <= Y0;
      month_w             <= 4'd1;
      r4                  <= R4_0;
      r100                <= R1H_0;
      r400                <= R4H_0;
      busy                <= 1'b0;
      done                <= 1'b0;
      overflow            <= 1'b0;
      centisecondsDisplay <= '0;
      secondsDisplay      <= '0;
      minutesDisplay      <= '0;
      hoursDisplay        <= '0;
      dayOfWeekDisplay    <= 3'(EPOCH_DOW);
      dateDisplay         <= 5'd1;
      monthDisplay        <= 4'd1;
      yearDisplay         <= Y0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, FINISH: begin
          state <= IDLE;
          if (convertStart) begin
            quo   <= tickCount;
            rem   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= DIV100;
          end
        end
        DIV100, DIV60S, DIV60M, DIV24, DIV7: begin
          cnt <= cnt + 6'd1;
          quo <= q_nx;
          rem <= r_nx;
          if (cnt == 6'd63) begin
            rem <= '0;
            case (state)
              DIV100: begin
                cs_w  <= r_nx[6:0];
                state <= DIV60S;
              end
              DIV60S: begin
                sec_w <= r_nx[5:0];
                state <= DIV60M;
              end
              DIV60M: begin
                min_w <= r_nx[5:0];
                state <= DIV24;
              end
              DIV24: begin
                hr_w  <= r_nx[4:0];
                days  <= q_nx;
                quo   <= q_nx + 64'(EPOCH_DOW);
                state <= DIV7;
              end
              default: begin
                dow_w   <= r_nx[2:0];
                year_w  <= Y0;
                month_w <= 4'd1;
                r4      <= R4_0;
                r100    <= R1H_0;
                r400    <= R4H_0;
                state   <= YEAR;
              end
            endcase
          end
        end
        YEAR: begin
          if (days >= ylen) begin
            if (year_w == YMAX) begin
              // Date is unrepresentable; time and weekday still publish.
              centisecondsDisplay <= cs_w;
              secondsDisplay      <= sec_w;
              minutesDisplay      <= min_w;
              hoursDisplay        <= hr_w;
              dayOfWeekDisplay    <= dow_w;
              dateDisplay         <= '0;
              monthDisplay        <= '0;
              yearDisplay         <= '0;
              overflow            <= 1'b1;
              done                <= 1'b1;
              busy                <= 1'b0;
              state               <= FINISH;
            end else begin
              days   <= days - ylen;
              year_w <= year_w + 14'd1;
              r4     <= r4 + 2'd1;
              r100   <= (r100 == 7'd99) ? 7'd0 : r100 + 7'd1;
              r400   <= (r400 == 9'd399) ? 9'd0 : r400 + 9'd1;
            end
          end else begin
            state <= MONTH;
          end
        end
        MONTH: begin
          if (days >= mlen) begin
            days    <= days - mlen;
            month_w <= month_w + 4'd1;
          end else begin
            centisecondsDisplay <= cs_w;
            secondsDisplay      <= sec_w;
            minutesDisplay      <= min_w;
            hoursDisplay        <= hr_w;
            dayOfWeekDisplay    <= dow_w;
            dateDisplay         <= days[4:0] + 5'd1;
            monthDisplay        <= month_w;
            yearDisplay         <= year_w;
            overflow            <= 1'b0;
            done                <= 1'b1;
            busy                <= 1'b0;
            state               <= FINISH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_date_converter.sv
// Directed-vector bench for time_date_converter.
// Expected fields and latencies are hand-computed.
module tb_time_date_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] tick;
  logic        busy;
  logic        done;
  logic [6:0]  cs;
  logic [5:0]  sec;
  logic [5:0]  mins;
  logic [4:0]  hrs;
  logic [2:0]  dow;
  logic [4:0]  dt;
  logic [3:0]  mon;
  logic [13:0] yr;
  logic        ovf;

  time_date_converter dut (
    .clockSignal(clk),
    .reset(rst),
    .convertStart(start),
    .tickCount(tick),
    .busy(busy),
    .done(done),
    .centisecondsDisplay(cs),
    .secondsDisplay(sec),
    .minutesDisplay(mins),
    .hoursDisplay(hrs),
    .dayOfWeekDisplay(dow),
    .dateDisplay(dt),
    .monthDisplay(mon),
    .yearDisplay(yr),
    .overflow(ovf)
  );

  always #5 clk = ~clk;

  logic [23:0] tim_o;
  logic [22:0] dat_o;
  logic [3:0]  misc_o;
  assign tim_o  = {hrs, mins, sec, cs};
  assign dat_o  = {yr, mon, dt};
  assign misc_o = {dow, ovf};

  int total = 0;
  int bad = 0;

  function automatic logic [23:0] mk_t(int h, int m, int s, int c);
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  function automatic logic [22:0] mk_d(int y, int mo, int d);
    return {14'(y), 4'(mo), 5'(d)};
  endfunction

  function automatic logic [3:0] mk_m(int w, int o);
    return {3'(w), 1'(o)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] tick;
    logic [23:0] tim;
    logic [22:0] dat;
    logic [3:0]  misc;
    int          lat;
  } vec_t;

  vec_t v[8];

  task automatic run(input logic [63:0] t, output int lat);
    logic [23:0] t0;
    logic [22:0] d0;
    logic [3:0]  m0;
    logic        held;
    logic        busy_ok;
    @(negedge clk);
    tick  = t;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = tim_o;
    d0 = dat_o;
    m0 = misc_o;
    held = 1'b1;
    busy_ok = 1'b1;
    lat = -1;
    for (int k = 1; k <= 9000; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (tim_o !== t0 || dat_o !== d0 || misc_o !== m0) held = 1'b0;
    end
    chk("busy_during", 64'(busy_ok), 64'd1);
    chk("outputs_held", 64'(held), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    @(posedge clk);
    #1 chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  int lat;
  int ndone;
  int first;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tick = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_time", 64'(tim_o), 64'(mk_t(0, 0, 0, 0)));
    chk("rst_date", 64'(dat_o), 64'(mk_d(1970, 1, 1)));
    chk("rst_misc", 64'(misc_o), 64'(mk_m(4, 0)));
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    rst = 1'b0;

    v[0] = '{64'd0, mk_t(0, 0, 0, 0), mk_d(1970, 1, 1), mk_m(4, 0), 322};
    v[1] = '{64'd8639999, mk_t(23, 59, 59, 99), mk_d(1970, 1, 1),
             mk_m(4, 0), 322};
    v[2] = '{64'd8640000, mk_t(0, 0, 0, 0), mk_d(1970, 1, 2),
             mk_m(5, 0), 322};
    v[3] = '{64'd95182769678, mk_t(12, 34, 56, 78), mk_d(2000, 2, 29),
             mk_m(2, 0), 353};
    v[4] = '{64'd410754240000, mk_t(0, 0, 0, 0), mk_d(2100, 3, 1),
             mk_m(1, 0), 454};
    v[5] = '{64'd410754239999, mk_t(23, 59, 59, 99), mk_d(2100, 2, 28),
             mk_m(0, 0), 453};
    v[6] = '{64'hFFFF_FFFF_FFFF_FFFF, mk_t(0, 18, 36, 15), mk_d(0, 0, 0),
             mk_m(0, 1), 0};
    v[7] = '{64'd0, mk_t(0, 0, 0, 0), mk_d(1970, 1, 1), mk_m(4, 0), 322};

    for (int i = 0; i < 8; i++) begin
      run(v[i].tick, lat);
      chk($sformatf("v%0d_time", i), 64'(tim_o), 64'(v[i].tim));
      chk($sformatf("v%0d_date", i), 64'(dat_o), 64'(v[i].dat));
      chk($sformatf("v%0d_dow_ovf", i), 64'(misc_o), 64'(v[i].misc));
      if (v[i].lat > 0)
        chk($sformatf("v%0d_latency", i), 64'(lat), 64'(v[i].lat));
      else
        chk($sformatf("v%0d_lat_bound", i), 64'(lat > 0 && lat <= 8400),
            64'd1);
    end

    // Second request while busy must be dropped.
    @(negedge clk);
    tick = 64'd95182769678;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    first = -1;
    for (int k = 1; k <= 500; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first < 0) first = k;
      end
      if (k == 10) begin
        tick = 64'd0;
        start = 1'b1;
      end
      if (k == 11) start = 1'b0;
    end
    chk("ignore_done_count", 64'(ndone), 64'd1);
    chk("ignore_latency", 64'(first), 64'd353);
    chk("ignore_date", 64'(dat_o), 64'(mk_d(2000, 2, 29)));
    chk("ignore_time", 64'(tim_o), 64'(mk_t(12, 34, 56, 78)));

    // Reset in the middle of a conversion aborts it.
    @(negedge clk);
    tick = 64'd410754240000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int k = 1; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy_done", 64'({busy, done}), 64'd0);
    chk("abort_time", 64'(tim_o), 64'(mk_t(0, 0, 0, 0)));
    chk("abort_date", 64'(dat_o), 64'(mk_d(1970, 1, 1)));
    chk("abort_misc", 64'(misc_o), 64'(mk_m(4, 0)));
    rst = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
